// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and encodings for the data-memory arbiter and its lane formatter.
package data_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    OpLoad    = 2'b00,
    OpStore   = 2'b01,
    OpAmoAdd  = 2'b10,
    OpAmoSwap = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    SizeByte  = 2'b00,
    SizeHalf  = 2'b01,
    SizeWord  = 2'b10,
    SizeWordX = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StAmoWb  = 2'b10
  } state_t;

  localparam logic [3:0] WE_BYTE = 4'b0001;
  localparam logic [3:0] WE_HALF = 4'b0011;
  localparam logic [3:0] WE_WORD = 4'b1111;
  localparam logic [2:0] RE_BYTE = 3'b000;
  localparam logic [2:0] RE_WORD = 3'b111;

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational byte-lane formatter: write enables/lane data from size, and
// sign/zero extension of read data.
module mem_lane_fmt
  import data_mem_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rd_i,
  output logic [3:0]  we_o,
  output logic [7:0]  wd1_o,
  output logic [7:0]  wd2_o,
  output logic [7:0]  wd3_o,
  output logic [7:0]  wd4_o,
  output logic [31:0] rdata_o
);

  assign wd1_o = wdata_i[7:0];
  assign wd2_o = wdata_i[15:8];
  assign wd3_o = wdata_i[23:16];
  assign wd4_o = wdata_i[31:24];

  always_comb begin
    we_o    = WE_WORD;
    rdata_o = rd_i;
    case (size_t'(size_i))
      SizeByte: begin
        we_o    = WE_BYTE;
        rdata_o = {{24{~unsigned_i & rd_i[7]}}, rd_i[7:0]};
      end
      SizeHalf: begin
        we_o    = WE_HALF;
        rdata_o = {{16{~unsigned_i & rd_i[15]}}, rd_i[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin front end for the byte-addressed data memory,
// sequencing loads, stores and atomic read-modify-writes.
module data_mem_arbiter
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     r0_valid,
  output logic                     r0_ready,
  input  logic [1:0]               r0_op,
  input  logic [1:0]               r0_size,
  input  logic                     r0_unsigned,
  input  logic [ADDRESS_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0]    r0_wdata,
  output logic                     r0_rsp_valid,
  output logic [DATA_WIDTH-1:0]    r0_rsp_rdata,
  input  logic                     r1_valid,
  output logic                     r1_ready,
  input  logic [1:0]               r1_op,
  input  logic [1:0]               r1_size,
  input  logic                     r1_unsigned,
  input  logic [ADDRESS_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0]    r1_wdata,
  output logic                     r1_rsp_valid,
  output logic [DATA_WIDTH-1:0]    r1_rsp_rdata,
  output logic [ADDRESS_WIDTH-1:0] mem_A,
  output logic [2:0]               mem_RE,
  output logic [3:0]               mem_WE,
  output logic [7:0]               mem_WD1,
  output logic [7:0]               mem_WD2,
  output logic [7:0]               mem_WD3,
  output logic [7:0]               mem_WD4,
  input  logic [31:0]              mem_RD
);

  state_t                   state_q, state_d;
  logic                     last_grant_q, last_grant_d;
  op_t                      op_q, op_d;
  size_t                    size_q, size_d;
  logic                     uns_q, uns_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    old_q, old_d;
  logic                     r0_rsp_valid_q, r0_rsp_valid_d, r1_rsp_valid_q, r1_rsp_valid_d;
  logic [DATA_WIDTH-1:0]    r0_rdata_q, r0_rdata_d, r1_rdata_q, r1_rdata_d;

  logic                  sel_r1, gnt_any, is_amo, rsp_fire;
  logic [DATA_WIDTH-1:0] rsp_data, amo_res, fmt_wdata, fmt_rdata;
  logic [1:0]            fmt_size;
  logic [3:0]            fmt_we;
  logic [7:0]            fmt_wd1, fmt_wd2, fmt_wd3, fmt_wd4;

  // Contention goes to the requester that did not win last; otherwise whoever asks.
  assign sel_r1   = (r0_valid && r1_valid) ? ~last_grant_q : r1_valid;
  // Gating with rst_n keeps ready low while reset is held with valid asserted.
  assign gnt_any  = (state_q == StIdle) && rst_n && (r0_valid || r1_valid);
  assign r0_ready = gnt_any && !sel_r1;
  assign r1_ready = gnt_any && sel_r1;

  assign is_amo    = op_q[1];
  assign amo_res   = (op_q == OpAmoAdd) ? old_q + wdata_q : wdata_q;
  assign fmt_size  = (state_q == StAccess && !is_amo) ? size_q : SizeWord;
  assign fmt_wdata = (state_q == StAmoWb) ? amo_res : wdata_q;

  mem_lane_fmt u_fmt (
    .size_i     (fmt_size),
    .unsigned_i (uns_q),
    .wdata_i    (fmt_wdata),
    .rd_i       (mem_RD),
    .we_o       (fmt_we),
    .wd1_o      (fmt_wd1),
    .wd2_o      (fmt_wd2),
    .wd3_o      (fmt_wd3),
    .wd4_o      (fmt_wd4),
    .rdata_o    (fmt_rdata)
  );

  always_comb begin
    mem_A   = '0;
    mem_RE  = RE_WORD;
    mem_WE  = '0;
    mem_WD1 = '0;
    mem_WD2 = '0;
    mem_WD3 = '0;
    mem_WD4 = '0;
    if (state_q == StAccess || state_q == StAmoWb) begin
      mem_A = addr_q;
      if (state_q == StAccess && !is_amo && size_q == SizeByte) mem_RE = RE_BYTE;
      if (state_q == StAmoWb || op_q == OpStore) begin
        mem_WE  = fmt_we;
        mem_WD1 = fmt_wd1;
        mem_WD2 = fmt_wd2;
        mem_WD3 = fmt_wd3;
        mem_WD4 = fmt_wd4;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    op_d           = op_q;
    size_d         = size_q;
    uns_d          = uns_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    old_d          = old_q;
    r0_rdata_d     = r0_rdata_q;
    r1_rdata_d     = r1_rdata_q;
    r0_rsp_valid_d = 1'b0;
    r1_rsp_valid_d = 1'b0;
    rsp_fire       = 1'b0;
    rsp_data       = '0;
    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          op_d         = op_t'(sel_r1 ? r1_op : r0_op);
          size_d       = size_t'(sel_r1 ? r1_size : r0_size);
          uns_d        = sel_r1 ? r1_unsigned : r0_unsigned;
          addr_d       = sel_r1 ? r1_addr : r0_addr;
          wdata_d      = sel_r1 ? r1_wdata : r0_wdata;
          last_grant_d = sel_r1;
          state_d      = StAccess;
        end
      end
      StAccess: begin
        if (is_amo) begin
          old_d   = mem_RD;
          state_d = StAmoWb;
        end else begin
          rsp_fire = 1'b1;
          rsp_data = (op_q == OpLoad) ? fmt_rdata : '0;
          state_d  = StIdle;
        end
      end
      StAmoWb: begin
        rsp_fire = 1'b1;
        rsp_data = old_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (rsp_fire) begin
      if (last_grant_q) begin
        r1_rsp_valid_d = 1'b1;
        r1_rdata_d     = rsp_data;
      end else begin
        r0_rsp_valid_d = 1'b1;
        r0_rdata_d     = rsp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      last_grant_q   <= 1'b1;
      op_q           <= OpLoad;
      size_q         <= SizeByte;
      uns_q          <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      old_q          <= '0;
      r0_rsp_valid_q <= 1'b0;
      r1_rsp_valid_q <= 1'b0;
      r0_rdata_q     <= '0;
      r1_rdata_q     <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      op_q           <= op_d;
      size_q         <= size_d;
      uns_q          <= uns_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      old_q          <= old_d;
      r0_rsp_valid_q <= r0_rsp_valid_d;
      r1_rsp_valid_q <= r1_rsp_valid_d;
      r0_rdata_q     <= r0_rdata_d;
      r1_rdata_q     <= r1_rdata_d;
    end
  end

  assign r0_rsp_valid = r0_rsp_valid_q;
  assign r1_rsp_valid = r1_rsp_valid_q;
  assign r0_rsp_rdata = r0_rdata_q;
  assign r1_rsp_rdata = r1_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter with a byte-addressed memory model.
module tb_data_mem_arbiter;

  localparam logic [1:0] LD = 2'b00, ST = 2'b01, AADD = 2'b10, ASWP = 2'b11;
  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_valid, r0_ready, r0_unsigned, r0_rsp_valid;
  logic [1:0]  r0_op, r0_size;
  logic [31:0] r0_addr, r0_wdata, r0_rsp_rdata;
  logic        r1_valid, r1_ready, r1_unsigned, r1_rsp_valid;
  logic [1:0]  r1_op, r1_size;
  logic [31:0] r1_addr, r1_wdata, r1_rsp_rdata;
  logic [31:0] mem_A, mem_RD;
  logic [2:0]  mem_RE;
  logic [3:0]  mem_WE;
  logic [7:0]  mem_WD1, mem_WD2, mem_WD3, mem_WD4;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          glog[$];
  logic        log_en = 1'b0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_size(r0_size),
    .r0_unsigned(r0_unsigned), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_size(r1_size),
    .r1_unsigned(r1_unsigned), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata),
    .mem_A(mem_A), .mem_RE(mem_RE), .mem_WE(mem_WE),
    .mem_WD1(mem_WD1), .mem_WD2(mem_WD2), .mem_WD3(mem_WD3), .mem_WD4(mem_WD4),
    .mem_RD(mem_RD)
  );

  // Little-endian byte memory, 1 KiB, address wraps within the model.
  logic [7:0] mem [0:1023];
  logic [9:0] ma;
  assign ma     = mem_A[9:0];
  assign mem_RD = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};

  always @(posedge clk) begin
    if (mem_WE[0]) mem[ma]         <= mem_WD1;
    if (mem_WE[1]) mem[ma + 10'd1] <= mem_WD2;
    if (mem_WE[2]) mem[ma + 10'd2] <= mem_WD3;
    if (mem_WE[3]) mem[ma + 10'd3] <= mem_WD4;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Response monitor: every pulse must match the owner's next expected value.
  always @(negedge clk) begin
    if (r0_rsp_valid) begin
      if (q0.size() == 0) check("r0 stray rsp", 32'(r0_rsp_valid), 32'd0);
      else check("r0 rsp rdata", r0_rsp_rdata, q0.pop_front());
    end
    if (r1_rsp_valid) begin
      if (q1.size() == 0) check("r1 stray rsp", 32'(r1_rsp_valid), 32'd0);
      else check("r1 rsp rdata", r1_rsp_rdata, q1.pop_front());
    end
    if (log_en && r0_ready) glog.push_back(0);
    if (log_en && r1_ready) glog.push_back(1);
  end

  task automatic drive(input bit rq, input logic v, input logic [1:0] op, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    if (rq) begin
      r1_valid = v; r1_op = op; r1_size = sz; r1_unsigned = uns; r1_addr = addr; r1_wdata = wd;
    end else begin
      r0_valid = v; r0_op = op; r0_size = sz; r0_unsigned = uns; r0_addr = addr; r0_wdata = wd;
    end
  endtask

  // Returns 1 ns after the handshake edge with valid dropped.
  task automatic issue(input bit rq, input logic [1:0] op, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd);
    int  waited = 0;
    bit  got = 0;
    @(posedge clk); #1;
    drive(rq, 1'b1, op, sz, uns, addr, wd);
    while (!got && waited < 50) begin
      @(negedge clk);
      if (rq ? r1_ready : r0_ready) got = 1;
      else waited++;
    end
    if (!got) begin
      check("handshake timeout", 32'd0, 32'd1);
      drive(rq, 1'b0, op, sz, uns, addr, wd);
      return;
    end
    if (rq) q1.push_back(exp_rd);
    else q0.push_back(exp_rd);
    @(posedge clk); #1;
    drive(rq, 1'b0, op, sz, uns, addr, wd);
  endtask

  task automatic issue_wait(input bit rq, input logic [1:0] op, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] exp_rd, input logic [3:0] exp_we, input int exp_lat);
    int lat;
    issue(rq, op, sz, uns, addr, wd, exp_rd);
    @(negedge clk);
    lat = 1;
    check("WE in ACCESS", 32'(mem_WE), 32'(exp_we));
    while (!(rq ? r1_rsp_valid : r0_rsp_valid) && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("rsp latency", 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (%0d/%0d so far)", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    drive(1'b0, 1'b1, LD, SW, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b1, LD, SW, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("reset r0_ready", 32'(r0_ready), 32'd0);
    check("reset r1_ready", 32'(r1_ready), 32'd0);
    check("reset mem_WE", 32'(mem_WE), 32'd0);
    check("reset mem_RE", 32'(mem_RE), 32'd7);
    check("reset mem_A", mem_A, 32'd0);
    check("reset r0_rsp_valid", 32'(r0_rsp_valid), 32'd0);
    check("reset r0_rsp_rdata", r0_rsp_rdata, 32'd0);
    rst_n = 1'b1;
    #1;
    check("first grant r0", 32'(r0_ready), 32'd1);
    check("first grant not r1", 32'(r1_ready), 32'd0);
    q0.push_back(32'h0);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    repeat (3) @(negedge clk);

    issue_wait(1'b0, ST, SW, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 4'b1111, 2);
    issue_wait(1'b0, LD, SW, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 4'b0000, 2);
    issue_wait(1'b0, LD, SB, 1'b0, 32'h103, 32'h0, 32'hFFFFFFDE, 4'b0000, 2);
    issue_wait(1'b0, LD, SB, 1'b1, 32'h103, 32'h0, 32'h000000DE, 4'b0000, 2);
    issue_wait(1'b0, LD, SH, 1'b0, 32'h102, 32'h0, 32'hFFFFDEAD, 4'b0000, 2);
    issue_wait(1'b0, LD, SH, 1'b1, 32'h102, 32'h0, 32'h0000DEAD, 4'b0000, 2);
    issue_wait(1'b0, ST, SH, 1'b0, 32'h104, 32'hAAAA1234, 32'h0, 4'b0011, 2);
    issue_wait(1'b0, LD, SW, 1'b0, 32'h104, 32'h0, 32'h00001234, 4'b0000, 2);
    issue_wait(1'b0, ST, SB, 1'b0, 32'h106, 32'hBBBBBB55, 32'h0, 4'b0001, 2);
    issue_wait(1'b0, LD, SX, 1'b0, 32'h104, 32'h0, 32'h00551234, 4'b0000, 2);

    issue_wait(1'b0, ST, SW, 1'b0, 32'h200, 32'h00000005, 32'h0, 4'b1111, 2);
    issue_wait(1'b0, AADD, SB, 1'b0, 32'h200, 32'hFFFFFFFF, 32'h00000005, 4'b0000, 3);
    issue_wait(1'b0, LD, SW, 1'b0, 32'h200, 32'h0, 32'h00000004, 4'b0000, 2);
    issue_wait(1'b0, ASWP, SW, 1'b0, 32'h200, 32'h12345678, 32'h00000004, 4'b0000, 3);
    issue_wait(1'b0, LD, SW, 1'b0, 32'h200, 32'h0, 32'h12345678, 4'b0000, 2);

    // r1 goes last so the contended round starts with r0.
    issue_wait(1'b1, LD, SW, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 4'b0000, 2);
    repeat (2) @(negedge clk);

    log_en = 1'b1;
    fork
      begin
        issue(1'b0, LD, SW, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF);
        issue(1'b0, LD, SB, 1'b1, 32'h300, 32'h0, 32'h0000000D);
      end
      begin
        issue(1'b1, ST, SW, 1'b0, 32'h300, 32'hCAFEF00D, 32'h0);
        issue(1'b1, LD, SW, 1'b0, 32'h300, 32'h0, 32'hCAFEF00D);
      end
    join
    repeat (4) @(negedge clk);
    log_en = 1'b0;
    check("grant count", 32'(glog.size()), 32'd4);
    if (glog.size() == 4) begin
      check("grant 0 owner", 32'(glog[0]), 32'd0);
      check("grant 1 owner", 32'(glog[1]), 32'd1);
      check("grant 2 owner", 32'(glog[2]), 32'd0);
      check("grant 3 owner", 32'(glog[3]), 32'd1);
    end
    check("r1 rdata held", r1_rsp_rdata, 32'hCAFEF00D);

    // Abort an AMOADD while its write-back is on the bus.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, AADD, SW, 1'b0, 32'h200, 32'h00000001);
    begin
      int w = 0;
      @(negedge clk);
      while (!r0_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      check("abort handshake", 32'(r0_ready), 32'd1);
    end
    @(posedge clk); #1;
    r0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("AMO_WB mem_WE", 32'(mem_WE), 32'hF);
    check("AMO_WB lane data", {mem_WD4, mem_WD3, mem_WD2, mem_WD1}, 32'h12345679);
    rst_n = 1'b0;
    #1;
    check("abort mem_WE", 32'(mem_WE), 32'd0);
    repeat (2) @(negedge clk);
    check("abort no rsp", 32'(r0_rsp_valid), 32'd0);
    check("abort r1 rdata cleared", r1_rsp_rdata, 32'd0);
    rst_n = 1'b1;
    issue_wait(1'b0, LD, SW, 1'b0, 32'h200, 32'h0, 32'h12345678, 4'b0000, 2);

    repeat (3) @(negedge clk);
    check("r0 queue drained", 32'(q0.size()), 32'd0);
    check("r1 queue drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-port controller in front of the byte-addressed data memory.
- Arbitrates between requester 0 (core load/store unit) and requester 1 (DMA/debug) using round-robin.
- Sequences each granted access, including an atomic read-modify-write, onto the memory's RE/WE/A/WD1-4 interface.
- Formats write byte lanes and sign/zero-extends read data.
- Returns a registered one-cycle response pulse to the granted requester.

Parameters:
- ADDRESS_WIDTH, 32, byte address width on both the requester and memory sides.
- DATA_WIDTH, 32, requester data width; must be 32 because the memory exposes 4 byte lanes.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous and active-low.
- rN_valid  input  1  request valid (N = 0, 1; likewise for every rN_* port).
- rN_ready  output  1  request accepted this cycle.
- rN_op  input  2  operation: 00 LOAD, 01 STORE, 10 AMOADD, 11 AMOSWAP.
- rN_size  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- rN_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
- rN_addr  input  ADDRESS_WIDTH  byte address; any alignment is allowed.
- rN_wdata  input  DATA_WIDTH  store/AMO operand; low bytes are used for sub-word sizes.
- rN_rsp_valid  output  1  one-cycle completion pulse.
- rN_rsp_rdata  output  DATA_WIDTH  load result, or the old memory value for AMO; 0 for STORE.
- mem_A  output  ADDRESS_WIDTH  memory base address.
- mem_RE  output  3  3'b000 for a byte read, 3'b111 for a word read.
- mem_WE  output  4  byte-lane write enables.
- mem_WD1..mem_WD4  output  8 each  lane data, lane 1 = least significant byte.
- mem_RD  input  32  combinational read data from memory.

Behaviour:
- States: IDLE, ACCESS, AMO_WB. Reset state is IDLE.
- Reset values: rN_ready=0, rN_rsp_valid=0, rN_rsp_rdata=0, mem_WE=0, mem_RE=3'b111, mem_A=0, mem_WD*=0, last_grant=1 (requester 0 wins first), all request registers 0.
- Asserting rst_n low mid-operation aborts the access.
  - mem_WE is forced to 0 immediately, with no partial write.
  - No response is issued.
- IDLE arbitration:
  - If one rN_valid is high, grant it.
  - If both are high, grant the requester != last_grant.
  - rN_ready is combinational and is high only in IDLE for the grantee.
  - On handshake (valid & ready): latch op/size/unsigned/addr/wdata, update last_grant, go to ACCESS.
- Request rules:
  - Requesters hold valid and payload stable until ready.
  - A requester that is not granted sees ready=0 and may keep waiting.
- ACCESS, LOAD:
  - mem_A=addr. mem_RE=000 for byte, else 111. mem_WE=0.
  - At the clock edge: rsp_rdata is formed from mem_RD.
    - Byte: RD[7:0] extended.
    - Half: RD[15:0] extended.
    - Word: RD as-is.
  - rsp_valid=1 for the next cycle; return to IDLE.
- ACCESS, STORE:
  - Byte-lane enables: byte 0001, half 0011, word 1111.
  - Lane data: WD1=wdata[7:0], WD2=[15:8], WD3=[23:16], WD4=[31:24].
  - The write occurs at the edge; rsp_valid pulses next cycle with rdata=0; return to IDLE.
- ACCESS, AMO (size forced to word):
  - Read with RE=111 and capture mem_RD into old_q; go to AMO_WB.
- AMO_WB:
  - mem_WE=1111; lane data = old_q+wdata (AMOADD, mod 2^32, carry discarded) or wdata (AMOSWAP).
  - At the edge: rsp_valid with rdata=old_q; return to IDLE.
- Latency (handshake edge = E):
  - LOAD/STORE: rsp_valid is high in the cycle after edge E+1.
  - AMO: rsp_valid is high after edge E+2.
- Throughput: 2 cycles per LOAD/STORE, 3 per AMO. A new request is never accepted during the response cycle's preceding states; IDLE coincides with the rsp pulse cycle, so back-to-back is allowed.
- Responses: rsp_valid is routed only to the requester recorded in the grant register. There is no response back-pressure. rsp_rdata holds its value until the next response to that requester.
- Address wrap: A+1..A+3 wrapping is handled by memory; the controller does no address arithmetic beyond passing addr.

Decomposition:
- Package data_mem_ctrl_pkg:
  - op_t enum (LOAD/STORE/AMOADD/AMOSWAP).
  - size_t enum.
  - state_t enum (IDLE/ACCESS/AMO_WB).
  - constants WE_BYTE=4'b0001, WE_HALF=4'b0011, WE_WORD=4'b1111, RE_BYTE=3'b000, RE_WORD=3'b111.
- Sub-module mem_lane_fmt (combinational):
  - size/unsigned/wdata -> WE and WD1-4.
  - mem_RD -> extended rdata.
- The top module holds the arbiter, FSM and registers.

Test Plan:
- Reset: rst_n low with r0_valid=1 -> ready=0, mem_WE=0, rsp_valid=0. After release, r0 is granted first.
- Store/load word:
  - r0 STORE word addr 0x100, wdata 0xDEADBEEF -> WE=1111 in ACCESS, rsp after 2 cycles.
  - r0 LOAD word 0x100 -> rdata 0xDEADBEEF.
- Sub-word load: load byte 0x103 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE. Half at 0x102 signed -> 0xFFFFDEAD.
- Contention: both valid for 4 consecutive requests -> grants alternate r0, r1, r0, r1. Each rsp goes only to its owner.
- AMOADD:
  - mem[0x200]=0x00000005, wdata 0xFFFFFFFF -> rsp rdata=5; subsequent load gives 0x00000004.
  - AMOSWAP of 0x12345678 returns 4.
- Abort: assert rst_n in AMO_WB -> no write. The location keeps its old value and no rsp is issued.
